// File: rtl/player_mover_if.sv
// Move request/response bundle between a controller and player_mover.
// Controller side uses master; the mover uses slave.
interface player_mover_if;
  logic       move_req;
  logic [1:0] dir;
  logic       move_ack;
  logic       blocked;
  logic       busy;

  modport master (
    output move_req,
    output dir,
    input  move_ack,
    input  blocked,
    input  busy
  );

  modport slave (
    input  move_req,
    input  dir,
    output move_ack,
    output blocked,
    output busy
  );
endinterface

// File: rtl/player_mover.sv
// Tile-stepping player mover with wall lookup and post-move cooldown.
// Define NOCLIP_EN to ignore maze walls; only the maze bounds then block.
module player_mover #(
  parameter int CELL_SIZE     = 16,
  parameter int MAZE_X0       = 64,
  parameter int MAZE_Y0       = 64,
  parameter int START_X       = 1,
  parameter int START_Y       = 1,
  parameter int MOVE_COOLDOWN = 5000000
) (
  input  logic        clk,
  input  logic        resetn,
  player_mover_if.slave mv,
  output logic [3:0]  map_addr,
  input  logic [29:0] map_data,
  output logic [4:0]  tile_x,
  output logic [3:0]  tile_y,
  output logic [9:0]  px_x,
  output logic [8:0]  px_y
);

  localparam int CW    = $clog2(MOVE_COOLDOWN) + 1;
  localparam int CS_SH = $clog2(CELL_SIZE);

  localparam logic [4:0]  LAST_COL = 5'd29;
  localparam logic [3:0]  LAST_ROW = 4'd11;
  localparam logic [4:0]  ST_X     = 5'(START_X);
  localparam logic [3:0]  ST_Y     = 4'(START_Y);
  localparam logic [9:0]  X0       = 10'(MAZE_X0);
  localparam logic [8:0]  Y0       = 9'(MAZE_Y0);
  localparam logic [CW-1:0] CD_LOAD = CW'(MOVE_COOLDOWN - 1);
  localparam logic [29:0] COL0_BIT = 30'h2000_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_DONE,
    S_COOL
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [4:0]    r_tile_x;
  logic [3:0]    r_tile_y;
  logic [4:0]    r_tgt_x;
  logic [3:0]    r_tgt_y;
  logic          r_oob;
  logic          r_blocked;
  logic [CW-1:0] r_cnt;

  logic [4:0]    w_tx;
  logic [3:0]    w_ty;
  logic          w_oob;
  logic          w_wall;

  // Out-of-bounds targets keep the current tile so the lookup row stays valid
  always_comb begin
    w_tx  = r_tile_x;
    w_ty  = r_tile_y;
    w_oob = 1'b0;
    unique case (1'b1)
      (mv.dir == 2'b00): begin
        if (r_tile_y == 4'd0) w_oob = 1'b1;
        else w_ty = r_tile_y - 4'd1;
      end
      (mv.dir == 2'b01): begin
        if (r_tile_y >= LAST_ROW) w_oob = 1'b1;
        else w_ty = r_tile_y + 4'd1;
      end
      (mv.dir == 2'b10): begin
        if (r_tile_x == 5'd0) w_oob = 1'b1;
        else w_tx = r_tile_x - 5'd1;
      end
      default: begin
        if (r_tile_x >= LAST_COL) w_oob = 1'b1;
        else w_tx = r_tile_x + 5'd1;
      end
    endcase
  end

`ifdef NOCLIP_EN
  logic w_unused_map;
  assign w_unused_map = ^map_data;
  assign w_wall       = 1'b0;
`else
  assign w_wall = |(map_data & (COL0_BIT >> r_tgt_x));
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (mv.move_req) w_next = S_LOOKUP;
      S_LOOKUP: w_next = S_DONE;
      S_DONE:   w_next = r_blocked ? S_IDLE : S_COOL;
      S_COOL:   if (r_cnt == '0) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_tile_x  <= ST_X;
      r_tile_y  <= ST_Y;
      r_tgt_x   <= ST_X;
      r_tgt_y   <= ST_Y;
      r_oob     <= 1'b0;
      r_blocked <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (mv.move_req) begin
            r_tgt_x <= w_tx;
            r_tgt_y <= w_ty;
            r_oob   <= w_oob;
          end
        end
        S_LOOKUP: r_blocked <= w_wall | r_oob;
        S_DONE: begin
          if (!r_blocked) begin
            r_tile_x <= r_tgt_x;
            r_tile_y <= r_tgt_y;
          end
          r_cnt <= CD_LOAD;
        end
        S_COOL: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign map_addr    = (r_state == S_LOOKUP) ? r_tgt_y : r_tile_y;
  assign mv.move_ack = (r_state == S_DONE);
  assign mv.blocked  = r_blocked;
  assign mv.busy     = (r_state != S_IDLE);

  assign tile_x = r_tile_x;
  assign tile_y = r_tile_y;
  assign px_x   = X0 + ({5'd0, r_tile_x} << CS_SH);
  assign px_y   = Y0 + ({5'd0, r_tile_y} << CS_SH);

endmodule

// File: tb/tb_player_mover.sv
// Randomized bench for player_mover against a transaction-level model.
// Checks ack latency, blocking, position, cooldown length and reset abort.
module tb_player_mover;
  localparam int MC = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  map_addr;
  logic [29:0] map_data;
  logic [4:0]  tile_x;
  logic [3:0]  tile_y;
  logic [9:0]  px_x;
  logic [8:0]  px_y;
  logic [29:0] maze [16];

  int n_vec = 0;
  int n_err = 0;
  int pos_x = 1;
  int pos_y = 1;

  player_mover_if mif();

  player_mover #(
    .MOVE_COOLDOWN(MC)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .mv       (mif),
    .map_addr (map_addr),
    .map_data (map_data),
    .tile_x   (tile_x),
    .tile_y   (tile_y),
    .px_x     (px_x),
    .px_y     (px_y)
  );

  always #5 clk = ~clk;
  assign map_data = maze[map_addr];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit mdl(int x, int y, int d,
                             output int nx, output int ny);
    logic [29:0] row;
    nx = x;
    ny = y;
    case (d)
      0: ny = y - 1;
      1: ny = y + 1;
      2: nx = x - 1;
      default: nx = x + 1;
    endcase
    if (nx < 0 || nx > 29 || ny < 0 || ny > 11) begin
      nx = x;
      ny = y;
      return 1'b1;
    end
`ifdef NOCLIP_EN
    row = '0;
`else
    row = maze[ny];
`endif
    if (row[29-nx]) begin
      nx = x;
      ny = y;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic chk_pos(string tag);
    chk({tag, "_tx"}, 32'(tile_x), 32'(pos_x));
    chk({tag, "_ty"}, 32'(tile_y), 32'(pos_y));
    chk({tag, "_px"}, 32'(px_x), 32'(64 + 16 * pos_x));
    chk({tag, "_py"}, 32'(px_y), 32'(64 + 16 * pos_y));
  endtask

  task automatic do_move(int d, bit disturb);
    int nx, ny, k, c, spur;
    bit eb;
    eb = mdl(pos_x, pos_y, d, nx, ny);
    mif.move_req = 1'b1;
    mif.dir      = 2'(d);
    k = 0;
    while (k < 8) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        mif.move_req = 1'b0;
        mif.dir      = 2'($urandom);
      end
      if (mif.move_ack) break;
    end
    chk("ack_lat", 32'(k), 32'd2);
    chk("blocked", 32'(mif.blocked), 32'(eb));
    chk("tx_pre", 32'(tile_x), 32'(pos_x));
    @(negedge clk);
    pos_x = nx;
    pos_y = ny;
    chk_pos("mv");
    c = 0;
    spur = 0;
    while (mif.busy && c < 50) begin
      if (disturb && c == 0) begin
        mif.move_req = 1'b1;
        mif.dir      = 2'($urandom);
      end
      if (c == 2) mif.move_req = 1'b0;
      c++;
      @(negedge clk);
      if (mif.move_ack) spur++;
    end
    mif.move_req = 1'b0;
    chk("cool_len", 32'(c), eb ? 32'd0 : 32'(MC));
    chk("spurious", 32'(spur), 32'd0);
    chk("blk_hold", 32'(mif.blocked), 32'(eb));
    chk("tx_hold", 32'(tile_x), 32'(pos_x));
    chk("ty_hold", 32'(tile_y), 32'(pos_y));
  endtask

  task automatic new_maze();
    for (int r = 0; r < 16; r++)
      maze[r] = (r < 12) ? 30'($urandom & $urandom) : '1;
  endtask

  initial begin
    int t [3];
    int na, cyc, acks;
    mif.move_req = 1'b0;
    mif.dir      = 2'b00;
    new_maze();
    maze[0] = '1;
    maze[1] = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk_pos("rst");
    chk("rst_busy", 32'(mif.busy), 32'd0);
    chk("rst_ack", 32'(mif.move_ack), 32'd0);
    chk("rst_blk", 32'(mif.blocked), 32'd0);

    do_move(0, 1'b0);
    do_move(3, 1'b0);
    chk("px96", 32'(px_x), 32'd96);
    chk("py80", 32'(px_y), 32'd80);

    mif.move_req = 1'b1;
    mif.dir      = 2'b11;
    acks = 0;
    cyc  = 0;
    while (acks < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (mif.move_ack) begin
        t[acks] = cyc;
        acks++;
      end
    end
    mif.move_req = 1'b0;
    chk("held_acks", 32'(acks), 32'd3);
    chk("held_int1", 32'(t[1] - t[0]), 32'(3 + MC));
    chk("held_int2", 32'(t[2] - t[1]), 32'(3 + MC));
    cyc = 0;
    while (mif.busy && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    pos_x = 5;
    chk_pos("held");

    mif.move_req = 1'b1;
    mif.dir      = 2'b11;
    @(negedge clk);
    mif.move_req = 1'b0;
    resetn = 1'b0;
    #1;
    pos_x = 1;
    pos_y = 1;
    chk("ar_busy", 32'(mif.busy), 32'd0);
    chk("ar_ack", 32'(mif.move_ack), 32'd0);
    chk("ar_blk", 32'(mif.blocked), 32'd0);
    chk_pos("ar");
    @(negedge clk);
    resetn = 1'b1;
    na = 0;
    repeat (6) begin
      @(negedge clk);
      if (mif.move_ack) na++;
    end
    chk("ar_noack", 32'(na), 32'd0);
    chk_pos("ar_post");

    for (int i = 0; i < 120; i++) begin
      if (i % 25 == 0) new_maze();
      do_move(int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/player_mover.md
PLAYER_MOVER -- requirements
Module: player_mover

Interface
REQ-001 Parameter CELL_SIZE, default 16, tile edge in pixels (power of two).
REQ-002 Parameter MAZE_X0, default 64, screen X of maze column 0.
REQ-003 Parameter MAZE_Y0, default 64, screen Y of maze row 0.
REQ-004 Parameter START_X, default 1, reset tile column (0..29).
REQ-005 Parameter START_Y, default 1, reset tile row (0..11).
REQ-006 Parameter MOVE_COOLDOWN, default 5000000, idle cycles after a committed move (>=1).
REQ-007 clk  in  1  single system clock; all state on rising edge.
REQ-008 resetn  in  1  asynchronous, active-low reset.
REQ-009 move_req  in  1  level; request one-tile step.
REQ-010 dir  in  2  00 up (row-1), 01 down (row+1), 10 left (col-1), 11 right (col+1).
REQ-011 map_addr  out  4  row index driven to combinational maze row lookup.
REQ-012 map_data  in  30  row bits; tile col c is wall when map_data[29-c]=1.
REQ-013 tile_x  out  5  current column; tile_y  out  4  current row.
REQ-014 px_x  out  10  MAZE_X0 + tile_x*CELL_SIZE; px_y  out  9  MAZE_Y0 + tile_y*CELL_SIZE.
REQ-015 move_ack  out  1  one-cycle pulse: request resolved.
REQ-016 blocked  out  1  valid with move_ack; 1 = move refused.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 FSM states IDLE, LOOKUP, DONE, COOLDOWN; encoding free.
REQ-019 IDLE: move_req=1 at edge n -> latch dir, compute target tile, enter LOOKUP.
REQ-020 Target outside cols 0..29 or rows 0..11 -> out-of-bounds flag latched; no wrap-around.
REQ-021 map_addr = target row in LOOKUP, = tile_y in all other states.
REQ-022 LOOKUP (cycle n+1): sample map_data[29-target_col]; result = wall OR out-of-bounds; enter DONE.
REQ-023 DONE (cycle n+2): move_ack=1; blocked=result; if result=0, tile_x/tile_y take target same edge.
REQ-024 DONE exit: committed move -> COOLDOWN; blocked move -> IDLE directly.
REQ-025 COOLDOWN: counter loads MOVE_COOLDOWN-1 on entry, decrements each cycle, at 0 -> IDLE; width $clog2(MOVE_COOLDOWN)+1.
REQ-026 move_req and dir ignored outside IDLE; no queuing; dir changes after latch have no effect.
REQ-027 Held move_req re-triggers on first IDLE cycle, giving one step per cooldown period.
REQ-028 px_x/px_y combinational from tile registers; CELL_SIZE multiply as shift.
REQ-029 blocked holds last value between acks; move_ack low except in DONE.

Reset
REQ-030 resetn=0 asynchronously forces: state IDLE, tile_x=START_X, tile_y=START_Y, move_ack=0, blocked=0, busy=0, counter=0.
REQ-031 Reset in LOOKUP/DONE/COOLDOWN aborts the request; no ack and no position change issued after release.
REQ-032 START tile is a non-wall tile; guaranteed by integrator, not checked.

Configuration
REQ-033 Macro NOCLIP_EN: defined -> map_data ignored, only bounds block moves; undefined -> wall and bounds both block.
REQ-034 With NOCLIP_EN, FSM timing (LOOKUP cycle included) unchanged.

Verification
REQ-035 Start (1,1), row 0 all wall, dir=00 pulse -> ack at n+2, blocked=1, tile stays (1,1), busy low at n+3.
REQ-036 Start (1,1), row 1 col 2 free, dir=11 -> ack n+2, blocked=0, tile (2,1), px_x=96, px_y=80.
REQ-037 MOVE_COOLDOWN=4, move_req held high, dir=11 on open row -> exactly one step per 7 cycles (3 FSM + 4 cooldown).
REQ-038 NOCLIP_EN defined, START (0,0), dir=10 -> blocked=1 (bounds); dir=01 into wall tile -> blocked=0, tile (0,1).
REQ-039 resetn low during LOOKUP -> outputs at reset values immediately, no move_ack after release, tile=(START_X,START_Y).
REQ-040 Request issued during COOLDOWN with different dir -> ignored, no ack, position unchanged until next IDLE request.
